// File: rtl/cmp_stream_driver.sv
// Initiator for an external registered max-comparator: folds a valid/ready element
// stream into max value, index of first maximum and element count per vector.
module cmp_stream_driver #(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = 8,
    parameter int CMP_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic [DATA_WIDTH-1:0] cmp_in1,
    output logic [DATA_WIDTH-1:0] cmp_in2,
    input  logic [DATA_WIDTH-1:0] cmp_out,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_max,
    output logic [IDX_WIDTH-1:0]  m_idx,
    output logic [IDX_WIDTH-1:0]  m_count,
    output logic                  m_ovf,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GET  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0]           WAIT_INIT = 3'(CMP_LAT);
    localparam logic [IDX_WIDTH-1:0] CNT_MAX   = {IDX_WIDTH{1'b1}};
    localparam logic [IDX_WIDTH-1:0] CNT_ONE   = {{(IDX_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_r;
    state_t                state_s;
    logic                  s_ready_r;
    logic                  m_valid_r;
    logic                  busy_r;
    logic                  s_ready_s;
    logic                  m_valid_s;
    logic                  busy_s;
    logic [DATA_WIDTH-1:0] best_r;
    logic [DATA_WIDTH-1:0] cand_r;
    logic [IDX_WIDTH-1:0]  best_idx_r;
    logic [IDX_WIDTH-1:0]  cand_idx_r;
    logic [IDX_WIDTH-1:0]  cnt_r;
    logic                  ovf_r;
    logic                  last_r;
    logic [2:0]            wcnt_r;
    logic                  s_hs_s;
    logic                  m_hs_s;

    assign s_hs_s  = s_valid & s_ready_r;
    assign m_hs_s  = m_valid_r & m_ready;

    assign s_ready = s_ready_r;
    assign m_valid = m_valid_r;
    assign busy    = busy_r;
    assign cmp_in1 = best_r;
    assign cmp_in2 = cand_r;
    assign m_max   = best_r;
    assign m_idx   = best_idx_r;
    assign m_count = cnt_r;
    assign m_ovf   = ovf_r;

    // State register plus handshake/status flops decoded from the upcoming state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= ST_IDLE;
            s_ready_r <= 1'b0;
            m_valid_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            s_ready_r <= s_ready_s;
            m_valid_r <= m_valid_s;
            busy_r    <= busy_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (s_hs_s) state_s = s_last ? ST_DONE : ST_GET;
                else        state_s = ST_IDLE;
            end
            ST_GET: begin
                if (s_hs_s) state_s = ST_WAIT;
                else        state_s = ST_GET;
            end
            ST_WAIT: begin
                if (wcnt_r == 3'd0) state_s = last_r ? ST_DONE : ST_GET;
                else                state_s = ST_WAIT;
            end
            ST_DONE: begin
                if (m_hs_s) state_s = ST_IDLE;
                else        state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode of the next state, registered above so outputs come from flops
    always_comb begin
        s_ready_s = 1'b0;
        m_valid_s = 1'b0;
        busy_s    = 1'b1;
        case (state_s)
            ST_IDLE: begin s_ready_s = 1'b1; busy_s = 1'b0; end
            ST_GET:  s_ready_s = 1'b1;
            ST_WAIT: s_ready_s = 1'b0;
            ST_DONE: m_valid_s = 1'b1;
            default: busy_s    = 1'b0;
        endcase
    end

    // Datapath: running best, candidate, counters; equal result keeps earlier index
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            best_r     <= '0;
            cand_r     <= '0;
            best_idx_r <= '0;
            cand_idx_r <= '0;
            cnt_r      <= '0;
            ovf_r      <= 1'b0;
            last_r     <= 1'b0;
            wcnt_r     <= 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (s_hs_s) begin
                        best_r     <= s_data;
                        best_idx_r <= '0;
                        cnt_r      <= CNT_ONE;
                        ovf_r      <= 1'b0;
                    end
                end
                ST_GET: begin
                    if (s_hs_s) begin
                        cand_r     <= s_data;
                        cand_idx_r <= cnt_r;
                        last_r     <= s_last;
                        wcnt_r     <= WAIT_INIT;
                        if (cnt_r == CNT_MAX) ovf_r <= 1'b1;
                        else                  cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_WAIT: begin
                    if (wcnt_r == 3'd0) begin
                        best_r <= cmp_out;
                        if (cmp_out != best_r) best_idx_r <= cand_idx_r;
                    end else begin
                        wcnt_r <= wcnt_r - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_stream_driver.sv
// Self-checking bench: two drivers (IDX_WIDTH 8 and 2) in lockstep on one stream,
// each with a registered unsigned-max comparator, checked against a vector-level model.
module tb_cmp_stream_driver;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = 16'd0;
    logic        s_last = 1'b0;
    logic        m_ready = 1'b0;

    logic        s_ready_a, m_valid_a, m_ovf_a, busy_a;
    logic [15:0] cmp_in1_a, cmp_in2_a, cmp_out_a, m_max_a;
    logic [7:0]  m_idx_a, m_count_a;
    logic        s_ready_b, m_valid_b, m_ovf_b, busy_b;
    logic [15:0] cmp_in1_b, cmp_in2_b, cmp_out_b, m_max_b;
    logic [1:0]  m_idx_b, m_count_b;

    int checks = 0;
    int errors = 0;
    logic [15:0] vq[$];

    always #5 clk = ~clk;

    cmp_stream_driver #(.DATA_WIDTH(16), .IDX_WIDTH(8), .CMP_LAT(1)) dut_a (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data),
        .s_last(s_last), .cmp_in1(cmp_in1_a), .cmp_in2(cmp_in2_a), .cmp_out(cmp_out_a),
        .m_valid(m_valid_a), .m_ready(m_ready), .m_max(m_max_a), .m_idx(m_idx_a),
        .m_count(m_count_a), .m_ovf(m_ovf_a), .busy(busy_a));

    cmp_stream_driver #(.DATA_WIDTH(16), .IDX_WIDTH(2), .CMP_LAT(1)) dut_b (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
        .s_last(s_last), .cmp_in1(cmp_in1_b), .cmp_in2(cmp_in2_b), .cmp_out(cmp_out_b),
        .m_valid(m_valid_b), .m_ready(m_ready), .m_max(m_max_b), .m_idx(m_idx_b),
        .m_count(m_count_b), .m_ovf(m_ovf_b), .busy(busy_b));

    always @(posedge clk) begin
        cmp_out_a <= (cmp_in1_a > cmp_in2_a) ? cmp_in1_a : cmp_in2_a;
        cmp_out_b <= (cmp_in1_b > cmp_in2_b) ? cmp_in1_b : cmp_in2_b;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Vector-level reference: max, first index of max, saturating count for width w
    task automatic ref_model(input int w, output logic [15:0] mx, output int idx,
                             output int cnt, output logic ovf);
        int lim;
        int fi;
        lim = (1 << w) - 1;
        mx  = vq[0];
        fi  = 0;
        for (int i = 1; i < vq.size(); i++) begin
            if (vq[i] > mx) begin
                mx = vq[i];
                fi = i;
            end
        end
        idx = (fi < lim) ? fi : lim;
        cnt = (vq.size() < lim) ? vq.size() : lim;
        ovf = (vq.size() > lim);
    endtask

    // Starts and ends on a negedge; returns on the negedge after the accepting posedge
    task automatic send(input logic [15:0] d, input logic l, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        t = 0;
        while (!s_ready_a && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("accept_ready", {31'd0, s_ready_a}, 32'd1);
        chk("lockstep_ready", {31'd0, s_ready_b}, {31'd0, s_ready_a});
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = 16'($urandom);
        s_last  = 1'($urandom);
    endtask

    task automatic get_result(input string nm, input logic [15:0] emax, input int eidx,
                              input int ecnt, input logic eovf, input int eidx2,
                              input int ecnt2, input logic eovf2, input int hold);
        int t;
        t = 0;
        while (!m_valid_a && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk({nm, " m_valid"}, {31'd0, m_valid_a}, 32'd1);
        chk({nm, " m_max"}, {16'd0, m_max_a}, {16'd0, emax});
        chk({nm, " m_idx"}, {24'd0, m_idx_a}, eidx);
        chk({nm, " m_count"}, {24'd0, m_count_a}, ecnt);
        chk({nm, " m_ovf"}, {31'd0, m_ovf_a}, {31'd0, eovf});
        chk({nm, " b_m_max"}, {16'd0, m_max_b}, {16'd0, emax});
        chk({nm, " b_m_idx"}, {30'd0, m_idx_b}, eidx2);
        chk({nm, " b_m_count"}, {30'd0, m_count_b}, ecnt2);
        chk({nm, " b_m_ovf"}, {31'd0, m_ovf_b}, {31'd0, eovf2});
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({nm, " hold_valid"}, {31'd0, m_valid_a}, 32'd1);
            chk({nm, " hold_ready"}, {31'd0, s_ready_a}, 32'd0);
            chk({nm, " hold_max"}, {16'd0, m_max_a}, {16'd0, emax});
            chk({nm, " hold_count"}, {24'd0, m_count_a}, ecnt);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk({nm, " post_valid"}, {31'd0, m_valid_a}, 32'd0);
        chk({nm, " post_ready"}, {31'd0, s_ready_a}, 32'd1);
        chk({nm, " post_busy"}, {31'd0, busy_a}, 32'd0);
    endtask

    task automatic run_vec(input string nm, input int gap, input int hold,
                           input logic [15:0] emax, input int eidx, input int ecnt,
                           input logic eovf);
        logic [15:0] mx2;
        int idx2, cnt2;
        logic ovf2;
        ref_model(2, mx2, idx2, cnt2, ovf2);
        for (int i = 0; i < vq.size(); i++) send(vq[i], (i == vq.size() - 1), gap);
        get_result(nm, emax, eidx, ecnt, eovf, idx2, cnt2, ovf2, hold);
    endtask

    typedef struct {
        int          len;
        logic [15:0] d [8];
        int          gap;
        int          hold;
        logic [15:0] emax;
        int          eidx;
        int          ecnt;
    } vec_t;

    vec_t tbl [7];

    initial begin
        logic [15:0] mx;
        int idx, cnt;
        logic ovf;

        tbl[0].len = 4; tbl[0].d = '{16'd3, 16'd9, 16'd9, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0};
        tbl[0].gap = 0; tbl[0].hold = 10; tbl[0].emax = 16'd9; tbl[0].eidx = 1; tbl[0].ecnt = 4;
        tbl[1].len = 1; tbl[1].d = '{16'd5, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        tbl[1].gap = 0; tbl[1].hold = 0; tbl[1].emax = 16'd5; tbl[1].eidx = 0; tbl[1].ecnt = 1;
        tbl[2].len = 3; tbl[2].d = '{16'd4, 16'd4, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        tbl[2].gap = 1; tbl[2].hold = 2; tbl[2].emax = 16'd4; tbl[2].eidx = 0; tbl[2].ecnt = 3;
        tbl[3].len = 5; tbl[3].d = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd0, 16'd0, 16'd0};
        tbl[3].gap = 0; tbl[3].hold = 0; tbl[3].emax = 16'd5; tbl[3].eidx = 4; tbl[3].ecnt = 5;
        tbl[4].len = 3; tbl[4].d = '{16'd9, 16'd8, 16'd7, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        tbl[4].gap = 2; tbl[4].hold = 1; tbl[4].emax = 16'd9; tbl[4].eidx = 0; tbl[4].ecnt = 3;
        tbl[5].len = 4; tbl[5].d = '{16'd0, 16'hFFFF, 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        tbl[5].gap = 0; tbl[5].hold = 0; tbl[5].emax = 16'hFFFF; tbl[5].eidx = 1; tbl[5].ecnt = 4;
        tbl[6].len = 8; tbl[6].d = '{16'd2, 16'd6, 16'd1, 16'd6, 16'd7, 16'd3, 16'd7, 16'd0};
        tbl[6].gap = 0; tbl[6].hold = 0; tbl[6].emax = 16'd7; tbl[6].eidx = 4; tbl[6].ecnt = 8;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst s_ready", {31'd0, s_ready_a}, 32'd0);
        chk("rst m_valid", {31'd0, m_valid_a}, 32'd0);
        chk("rst busy", {31'd0, busy_a}, 32'd0);
        chk("rst cmp_in1", {16'd0, cmp_in1_a}, 32'd0);
        chk("rst m_count", {24'd0, m_count_a}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst s_ready", {31'd0, s_ready_a}, 32'd1);

        foreach (tbl[k]) begin
            vq = {};
            for (int i = 0; i < tbl[k].len; i++) vq.push_back(tbl[k].d[i]);
            run_vec($sformatf("tbl%0d", k), tbl[k].gap, tbl[k].hold, tbl[k].emax,
                    tbl[k].eidx, tbl[k].ecnt, 1'b0);
        end

        // Single element: result valid on the cycle after acceptance
        send(16'd5, 1'b1, 0);
        chk("single next_cycle_valid", {31'd0, m_valid_a}, 32'd1);
        get_result("single", 16'd5, 0, 1, 1'b0, 0, 1, 1'b0, 0);

        // Input gaps with s_ready low exactly two clocks after a GET accept
        send(16'd1, 1'b0, 3);
        chk("gap first_ready", {31'd0, s_ready_a}, 32'd1);
        send(16'd7, 1'b0, 3);
        chk("gap ready_low0", {31'd0, s_ready_a}, 32'd0);
        @(negedge clk);
        chk("gap ready_low1", {31'd0, s_ready_a}, 32'd0);
        @(negedge clk);
        chk("gap ready_back", {31'd0, s_ready_a}, 32'd1);
        send(16'd4, 1'b1, 3);
        get_result("gaps", 16'd7, 1, 3, 1'b0, 1, 3, 1'b0, 0);

        // Reset during WAIT of element 2
        send(16'd3, 1'b0, 0);
        send(16'd5, 1'b0, 0);
        rstn = 1'b0;
        #1;
        chk("midrst s_ready", {31'd0, s_ready_a}, 32'd0);
        chk("midrst busy", {31'd0, busy_a}, 32'd0);
        chk("midrst cmp_in1", {16'd0, cmp_in1_a}, 32'd0);
        chk("midrst cmp_in2", {16'd0, cmp_in2_a}, 32'd0);
        chk("midrst m_max", {16'd0, m_max_a}, 32'd0);
        chk("midrst m_count", {24'd0, m_count_a}, 32'd0);
        repeat (2) @(negedge clk);
        chk("midrst m_valid", {31'd0, m_valid_a}, 32'd0);
        rstn = 1'b1;
        vq = {16'd8};
        run_vec("after_rst", 0, 0, 16'd8, 0, 1, 1'b0);

        // Counter saturation: narrow instance saturates at 3
        vq = {16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd9};
        for (int i = 0; i < vq.size(); i++) send(vq[i], (i == vq.size() - 1), 0);
        get_result("ovf", 16'd9, 5, 6, 1'b0, 3, 3, 1'b1, 0);

        // Randomised vectors against the reference model
        for (int r = 0; r < 40; r++) begin
            int n;
            n = $urandom_range(1, 9);
            vq = {};
            for (int i = 0; i < n; i++)
                vq.push_back((r % 2 == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom));
            ref_model(8, mx, idx, cnt, ovf);
            run_vec($sformatf("rand%0d", r), $urandom_range(0, 2), $urandom_range(0, 3),
                    mx, idx, cnt, ovf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
